mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning word address width; array depth is 2^ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning word width.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_read_valid  input  1  read request from the requester (cache side).
REQ-007 SHALL have port mem_read_address  input  ADDR_BITS  read word address.
REQ-008 SHALL have port mem_read_ready  output  1  one-cycle read-done pulse.
REQ-009 SHALL have port mem_read_data  output  DATA_BITS  read word; valid while mem_read_ready=1.
REQ-010 SHALL have port mem_write_valid  input  1  write request.
REQ-011 SHALL have port mem_write_address  input  ADDR_BITS  write word address.
REQ-012 SHALL have port mem_write_data  input  DATA_BITS  write word.
REQ-013 SHALL have port mem_write_ready  output  1  one-cycle write-done pulse.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP, plus a latched op (READ/WRITE), address, write data, and a 4-bit down-counter.
REQ-015 SHALL, in IDLE at an edge where mem_read_valid=1, latch the read address, set op=READ, load counter=LATENCY-1, and enter WAIT.
REQ-016 SHALL, in IDLE at an edge where only mem_write_valid=1, latch the write address and data, set op=WRITE, load the counter, and enter WAIT.
REQ-017 SHALL give reads priority when both valids are high in IDLE; the write remains pending until a later IDLE edge.
REQ-018 SHALL, in WAIT, decrement the counter when it is nonzero; when it is 0, assert the ready output matching op, and enter RESP.
REQ-019 SHALL, for READ, drive mem_read_data from array[latched address] at the same edge that raises mem_read_ready.
REQ-020 SHALL, for WRITE, update array[latched address] with the latched data at the same edge that raises mem_write_ready.
REQ-021 SHALL, in RESP, deassert both ready outputs and return to IDLE, so each ready is high for exactly one cycle.
REQ-022 SHALL raise the ready in the cycle following edge N+LATENCY for a request accepted at edge N, giving a minimum request-to-request spacing of LATENCY+2 cycles.
REQ-023 SHALL sample new valid/address only in IDLE, so a requester that holds valid and advances its address after each ready (sequential block fill) receives each word in order.
REQ-024 SHALL complete an accepted request even if its valid drops during WAIT; inputs are ignored outside IDLE.
REQ-025 SHALL hold mem_read_data at its last value when not responding.
REQ-026 SHALL never assert mem_read_ready and mem_write_ready simultaneously.

Reset
REQ-027 SHALL, on reset, force state=IDLE, counter=0, mem_read_ready=0, mem_write_ready=0, mem_read_data=0, and all array words to 0.
REQ-028 SHALL let reset asserted in WAIT or RESP abort the request with no array write and no ready pulse, and SHALL accept a new request at the first IDLE edge after reset deasserts.

Configuration
REQ-029 SHALL, when macro MEM_RESPONDER_WRITE_EN is defined, perform array writes per REQ-020.
REQ-030 SHALL, when MEM_RESPONDER_WRITE_EN is undefined, still handshake writes with identical timing (mem_write_ready pulse) but leave the array unmodified (read-only program memory).

Verification
REQ-031 SHALL cover: with MEM_RESPONDER_WRITE_EN and LATENCY=2, write 0xA5 to address 0x13, then read 0x13 -> each ready is a single-cycle pulse 3 cycles after acceptance, and the read returns 0xA5.
REQ-032 SHALL cover: a sequential-fill requester reads addresses 0x20..0x23 with 0x11,0x22,0x33,0x44 pre-written -> four read pulses spaced LATENCY+2 cycles apart, data in order.
REQ-033 SHALL cover: read of 0x05 and write of 0x06 with valid both raised in the same cycle -> read pulse first, then write pulse LATENCY+2 cycles later, and no cycle with both readies high.
REQ-034 SHALL cover: read accepted, valid dropped the next cycle -> mem_read_ready still pulses once with correct data.
REQ-035 SHALL cover: reset asserted in WAIT of a write of 0xFF to 0x40 -> no ready pulse, and a following read of 0x40 returns 0x00.
REQ-036 SHALL cover: without MEM_RESPONDER_WRITE_EN, write 0x77 to 0x01 then read 0x01 -> write pulse occurs and the read returns 0x00.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency word memory that answers one read or write request at a time.
// Define MEM_RESPONDER_WRITE_EN to let writes modify the array; otherwise it behaves as read-only program memory.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_valid,
  input  logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_read_ready,
  output logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_valid,
  input  logic [ADDR_BITS-1:0] mem_write_address,
  input  logic [DATA_BITS-1:0] mem_write_data,
  output logic                 mem_write_ready
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

`ifdef MEM_RESPONDER_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state_reg;
  logic                   op_write_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [DATA_BITS-1:0]   wdata_reg;
  logic [3:0]             count_reg;
  logic [DATA_BITS-1:0]   mem_array [DEPTH];

  // The array is cleared on reset, so it lives in fabric registers rather than block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      op_write_reg    <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      count_reg       <= 4'd0;
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_read_data   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_array[i] <= '0;
      end
    end else begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_read_valid) begin
            op_write_reg <= 1'b0;
            addr_reg     <= mem_read_address;
            count_reg    <= COUNT_LOAD;
            state_reg    <= WAIT;
          end else if (mem_write_valid) begin
            op_write_reg <= 1'b1;
            addr_reg     <= mem_write_address;
            wdata_reg    <= mem_write_data;
            count_reg    <= COUNT_LOAD;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
          end else begin
            if (op_write_reg) begin
              mem_write_ready <= 1'b1;
              if (WRITE_EN) begin
                mem_array[addr_reg] <= wdata_reg;
              end
            end else begin
              mem_read_ready <= 1'b1;
              mem_read_data  <= mem_array[addr_reg];
            end
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array model of the memory.
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2;

`ifdef MEM_RESPONDER_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          rv;
  logic [AB-1:0] ra;
  logic          rrdy;
  logic [DB-1:0] rdata;
  logic          wv;
  logic [AB-1:0] wa;
  logic [DB-1:0] wd;
  logic          wrdy;

  int checks;
  int errors;
  int overlap;
  logic [DB-1:0] model_mem [1 << AB];

  mem_responder #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .LATENCY  (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (rv),
    .mem_read_address (ra),
    .mem_read_ready   (rrdy),
    .mem_read_data    (rdata),
    .mem_write_valid  (wv),
    .mem_write_address(wa),
    .mem_write_data   (wd),
    .mem_write_ready  (wrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rrdy === 1'b1 && wrdy === 1'b1) overlap++;
  end

  task automatic model_clear();
    for (int i = 0; i < (1 << AB); i++) model_mem[i] = '0;
  endtask

  // One isolated request from IDLE; returns at a negedge with the DUT idle again.
  task automatic run_req(input bit wr, input logic [AB-1:0] a, input logic [DB-1:0] d);
    int first;
    int highs;
    int others;
    logic [DB-1:0] got;
    logic [DB-1:0] exp;
    first = -1; highs = 0; others = 0; got = '0;
    exp = model_mem[a];
    if (wr) begin wv = 1'b1; wa = a; wd = d; end
    else begin rv = 1'b1; ra = a; end
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin rv = 1'b0; wv = 1'b0; end
      if (wr ? wrdy : rrdy) begin
        highs++;
        if (first < 0) begin first = c; got = rdata; end
      end
      if (wr ? rrdy : wrdy) others++;
    end
    checks++;
    if (first !== LAT + 1) begin
      errors++;
      $display("FAIL req_latency: got %0d expected %0d", first, LAT + 1);
    end
    checks++;
    if (highs !== 1) begin
      errors++;
      $display("FAIL req_pulse_count: got %0d expected 1", highs);
    end
    checks++;
    if (others !== 0) begin
      errors++;
      $display("FAIL req_wrong_ready: got %0d expected 0", others);
    end
    if (!wr) begin
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read_data: addr %02h got %02h expected %02h", a, got, exp);
      end
      $display("read  addr=%02h data=%02h expected=%02h latency=%0d", a, got, exp, first);
    end else begin
      if (WR_EN) model_mem[a] = d;
      $display("write addr=%02h data=%02h latency=%0d", a, d, first);
    end
  endtask

  task automatic test_reset();
    rv = 1'b0; wv = 1'b0; ra = '0; wa = '0; wd = '0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (rrdy !== 1'b0 || wrdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", rrdy, wrdy);
    end
    checks++;
    if (rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %02h expected 00", rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset done rdata=%02h", rdata);
  endtask

  task automatic test_write_read();
    run_req(1'b1, 8'h13, 8'hA5);
    run_req(1'b0, 8'h13, 8'h00);
    run_req(1'b1, 8'h01, 8'h77);
    run_req(1'b0, 8'h01, 8'h00);
  endtask

  task automatic test_seq_fill();
    logic [DB-1:0] vals [4];
    int idx;
    int last;
    int expc;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) run_req(1'b1, 8'(8'h20 + i), vals[i]);
    idx = 0; last = 0;
    rv = 1'b1; ra = 8'h20;
    for (int c = 1; c <= 4 * (LAT + 2) + 8 && idx < 4; c++) begin
      @(negedge clk);
      if (rrdy) begin
        expc = (idx == 0) ? LAT + 1 : last + LAT + 2;
        checks++;
        if (c !== expc) begin
          errors++;
          $display("FAIL fill_spacing: word %0d at cycle %0d expected %0d", idx, c, expc);
        end
        checks++;
        if (rdata !== model_mem[8'h20 + idx]) begin
          errors++;
          $display("FAIL fill_data: word %0d got %02h expected %02h", idx, rdata, model_mem[8'h20 + idx]);
        end
        $display("fill  addr=%02h data=%02h cycle=%0d", 8'(8'h20 + idx), rdata, c);
        last = c;
        idx++;
        if (idx == 4) rv = 1'b0;
        else ra = 8'(8'h20 + idx);
      end
    end
    rv = 1'b0;
    checks++;
    if (idx !== 4) begin
      errors++;
      $display("FAIL fill_count: got %0d expected 4", idx);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_both_valid();
    int rfirst;
    int wfirst;
    int rh;
    int wh;
    int ov0;
    logic [DB-1:0] got;
    logic [DB-1:0] d;
    logic [DB-1:0] exp;
    d = 8'($urandom_range(1, 255));
    exp = model_mem[8'h05];
    rfirst = -1; wfirst = -1; rh = 0; wh = 0; got = '0;
    ov0 = overlap;
    rv = 1'b1; ra = 8'h05; wv = 1'b1; wa = 8'h06; wd = d;
    for (int c = 1; c <= 2 * (LAT + 2) + 4; c++) begin
      @(negedge clk);
      if (c == 1) rv = 1'b0;
      if (rrdy) begin rh++; if (rfirst < 0) begin rfirst = c; got = rdata; end end
      if (wrdy) begin wh++; if (wfirst < 0) begin wfirst = c; wv = 1'b0; end end
    end
    wv = 1'b0;
    checks++;
    if (rfirst !== LAT + 1 || rh !== 1) begin
      errors++;
      $display("FAIL both_read_pulse: cycle %0d count %0d expected cycle %0d count 1", rfirst, rh, LAT + 1);
    end
    checks++;
    if (wfirst !== 2 * LAT + 3 || wh !== 1) begin
      errors++;
      $display("FAIL both_write_pulse: cycle %0d count %0d expected cycle %0d count 1", wfirst, wh, 2 * LAT + 3);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL both_read_data: got %02h expected %02h", got, exp);
    end
    checks++;
    if (overlap !== ov0) begin
      errors++;
      $display("FAIL both_overlap: got %0d expected 0", overlap - ov0);
    end
    if (WR_EN) model_mem[8'h06] = d;
    $display("both  read=%02h@%0d write=%02h@%0d", got, rfirst, d, wfirst);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_valid_drop();
    logic [AB-1:0] a;
    a = 8'($urandom_range(0, 7));
    run_req(1'b1, a, 8'($urandom_range(1, 255)));
    run_req(1'b0, a, 8'h00);
  endtask

  task automatic test_reset_in_wait();
    int wh;
    wh = 0;
    run_req(1'b1, 8'h40, 8'h3C);
    run_req(1'b0, 8'h40, 8'h00);
    wv = 1'b1; wa = 8'h40; wd = 8'hFF;
    @(negedge clk);
    wv = 1'b0;
    if (wrdy) wh++;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    if (wrdy) wh++;
    reset = 1'b0;
    checks++;
    if (rdata !== '0) begin
      errors++;
      $display("FAIL abort_rdata_reset: got %02h expected 00", rdata);
    end
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (wrdy || rrdy) wh++;
    end
    checks++;
    if (wh !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got %0d expected 0", wh);
    end
    $display("abort write addr=40 pulses=%0d", wh);
    run_req(1'b0, 8'h40, 8'h00);
  endtask

  task automatic test_random();
    bit wr;
    logic [AB-1:0] a;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      run_req(wr, a, 8'($urandom));
    end
  endtask

  initial begin
    checks = 0; errors = 0; overlap = 0;
    reset = 1'b1; rv = 1'b0; wv = 1'b0; ra = '0; wa = '0; wd = '0;
    test_reset();
    test_write_read();
    test_seq_fill();
    test_both_valid();
    test_valid_drop();
    test_reset_in_wait();
    test_random();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL ready_overlap_total: got %0d expected 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
